// File: rtl/key_expand_seq.sv
// AES key schedule generator: streams w[0..LAST] one word per accepted handshake.
// The window holds w[i..i+Nk-1]; w_out is window word 0, and each accepted word
// is replaced by w[i+Nk] = w[i] ^ temp(w[i+Nk-1]).
module key_expand_seq #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [0:KEY_BITS-1] key_in,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [0:31]         w_out,
    output logic [0:5]          w_index,
    output logic                busy,
    output logic                done
);

    localparam int unsigned NK       = KEY_BITS / 32;
    localparam int unsigned NR       = NK + 6;
    localparam logic [5:0]  LAST_IDX = 6'(4 * NR + 3);
    localparam logic [2:0]  NK_M1    = 3'(NK - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    state_t      state, next_state;
    logic [0:31] win [0:NK-1];
    logic [5:0]  idx;
    logic [2:0]  modc;
    logic [7:0]  rcon;
    logic [0:31] tail, temp, next_word;
    logic        hs;

    function automatic logic [0:31] sub_word(input logic [0:31] x);
        return {SBOX[x[0:7]], SBOX[x[8:15]], SBOX[x[16:23]], SBOX[x[24:31]]};
    endfunction

    assign busy    = (state == EMIT);
    assign done    = (state == FIN);
    assign w_valid = busy;
    assign w_out   = busy ? win[0] : '0;
    assign w_index = busy ? idx : '0;
    assign hs      = busy && w_ready;
    assign tail    = win[NK-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = EMIT;
            EMIT:    if (w_ready && idx == LAST_IDX) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Word w[i+Nk] from the oldest window word and the newest one
    always_comb begin
        temp = tail;
        if (modc == 3'd0)
            temp = sub_word({tail[8:31], tail[0:7]}) ^ {rcon, 24'h000000};
        else if (NK == 8 && modc == 3'd4)
            temp = sub_word(tail);
        next_word = win[0] ^ temp;
    end

    // Key window, word index, i mod Nk counter and Rcon doubling register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < NK; j++) win[j] <= '0;
            idx  <= '0;
            modc <= '0;
            rcon <= '0;
        end else if (state == IDLE && start) begin
            for (int unsigned j = 0; j < NK; j++) win[j] <= key_in[32*j +: 32];
            idx  <= '0;
            modc <= '0;
            rcon <= 8'h01;
        end else if (hs && idx != LAST_IDX) begin
            for (int unsigned j = 0; j + 1 < NK; j++) win[j] <= win[j+1];
            win[NK-1] <= next_word;
            idx       <= idx + 6'd1;
            modc      <= (modc == NK_M1) ? 3'd0 : modc + 3'd1;
            if (modc == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq at all three key lengths, with a reference
// key-schedule model whose S-box is derived from GF(2^8) inversion.
module tb_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start128, start192, start256;
    logic         rdy128, rdy192, rdy256;
    logic [0:127] key128;
    logic [0:191] key192;
    logic [0:255] key256;
    logic         v128, v192, v256, b128, b192, b256, d128, d192, d256;
    logic [0:31]  o128, o192, o256;
    logic [0:5]   x128, x192, x256;

    key_expand_seq #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .start(start128), .key_in(key128), .w_valid(v128),
        .w_ready(rdy128), .w_out(o128), .w_index(x128), .busy(b128), .done(d128));
    key_expand_seq #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst(rst), .start(start192), .key_in(key192), .w_valid(v192),
        .w_ready(rdy192), .w_out(o192), .w_index(x192), .busy(b192), .done(d192));
    key_expand_seq #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .start(start256), .key_in(key256), .w_valid(v256),
        .w_ready(rdy256), .w_out(o256), .w_index(x256), .busy(b256), .done(d256));

    int          nvec = 0;
    int          nfail = 0;
    logic [7:0]  sb [256];
    logic [31:0] exp_w [60];

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] KNEW  = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_tab(input int k);
        case (k)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic expand(input logic [0:255] key, input int nk);
        logic [31:0] t;
        for (int i = 0; i < 4 * (nk + 6) + 4; i++) begin
            if (i < nk) exp_w[i] = key[32*i +: 32];
            else begin
                t = exp_w[i-1];
                if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab(i / nk), 24'h000000};
                else if (nk == 8 && i % nk == 4) t = subw(t);
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int k;
        int cyc;
        logic r;

        build_sbox();
        rst = 1'b1;
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        rdy128 = 1'b0; rdy192 = 1'b0; rdy256 = 1'b0;
        key128 = K128; key192 = K192; key256 = K256;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", v128, 0); check("rst_out", o128, 0); check("rst_index", x128, 0);
        check("rst_busy", b128, 0);  check("rst_done", d128, 0);
        check("rst_valid256", v256, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", v128, 0);

        // 128-bit run, full throughput, key changed after accept, extra start at index 10
        expand({K128, 128'h0}, 4);
        key128 = K128; start128 = 1'b1; rdy128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        key128 = '1;
        dones = 0;
        for (int i = 0; i < 44; i++) begin
            check("v128", v128, 1); check("busy128", b128, 1);
            check("idx128", x128, i); check("w128", o128, exp_w[i]);
            if (i == 4)  check("w4_fips", o128, 32'ha0fafe17);
            if (i == 43) check("w43_fips", o128, 32'hb6630ca6);
            if (i == 10) start128 = 1'b1;
            if (i == 11) start128 = 1'b0;
            dones += int'(d128);
            @(negedge clk);
        end
        check("done128", d128, 1); check("fin_valid", v128, 0);
        check("fin_busy", b128, 0); check("fin_out", o128, 0);
        for (int i = 0; i < 4; i++) begin
            dones += int'(d128);
            @(negedge clk);
        end
        check("done_once", dones, 1);
        check("idle_after", v128, 0);

        // 192-bit run
        expand({K192, 64'h0}, 6);
        start192 = 1'b1; rdy192 = 1'b1;
        @(negedge clk);
        start192 = 1'b0;
        for (int i = 0; i < 52; i++) begin
            check("v192", v192, 1); check("idx192", x192, i); check("w192", o192, exp_w[i]);
            if (i == 6)  check("w6_fips", o192, 32'hfe0c91f7);
            if (i == 51) check("w51_fips", o192, 32'h01002202);
            @(negedge clk);
        end
        check("done192", d192, 1); check("fin_valid192", v192, 0);

        // 256-bit run
        expand(K256, 8);
        start256 = 1'b1; rdy256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            check("v256", v256, 1); check("idx256", x256, i); check("w256", o256, exp_w[i]);
            if (i == 8)  check("w8_fips", o256, 32'h9ba35411);
            if (i == 12) check("w12_fips", o256, 32'ha8b09c1a);
            if (i == 59) check("w59_fips", o256, 32'h706c631e);
            @(negedge clk);
        end
        check("done256", d256, 1); check("fin_valid256", v256, 0);

        // 128-bit run with random stalls
        expand({K128, 128'h0}, 4);
        key128 = K128; start128 = 1'b1; rdy128 = 1'b0;
        @(negedge clk);
        start128 = 1'b0;
        k = 0; cyc = 0;
        while (k < 44 && cyc < 400) begin
            check("stall_v", v128, 1); check("stall_idx", x128, k); check("stall_w", o128, exp_w[k]);
            r = ($urandom_range(0, 2) != 0);
            rdy128 = r;
            if (r) k++;
            cyc++;
            @(negedge clk);
        end
        check("stall_complete", k, 44);
        check("stall_done", d128, 1);
        rdy128 = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run, then a fresh run with a new key
        key128 = K128; start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        cyc = 0;
        while (x128 != 6'd20 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("reach_idx20", x128, 20);
        check("w20", o128, exp_w[20]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", v128, 0); check("mid_rst_out", o128, 0);
        check("mid_rst_index", x128, 0); check("mid_rst_busy", b128, 0);
        check("mid_rst_done", d128, 0);
        @(negedge clk);
        check("no_resume", v128, 0);
        expand({KNEW, 128'h0}, 4);
        key128 = KNEW; start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        check("new_w0", o128, 32'h00010203);
        for (int i = 0; i < 44; i++) begin
            check("new_idx", x128, i); check("new_w", o128, exp_w[i]);
            @(negedge clk);
        end
        check("new_done", d128, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
